// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave engine: state encoding and SPI mode decode.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      WAIT = 2'd3
   } state_e;

   // Index of the read/write flag inside the command word.
   function automatic int cmd_bit(input int word_w);
      return word_w - 1;
   endfunction

   function automatic logic cpol(input int mode);
      return mode[1];
   endfunction

   function automatic logic cpha(input int mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin, followed by rise/fall detection
// on the synchronised level.
module spi_edge_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_q, chain_d;
   logic              prev_q, prev_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], din};
      prev_d  = chain_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         chain_q <= {STAGES{RESET_VAL}};
         prev_q  <= RESET_VAL;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
      end
   end

   assign level = chain_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave transaction engine: command word (R/W flag + start address) followed by
// auto-incrementing data words written to, or read from, the PWM register file.
module spi_slave_fsm #(
   parameter int WORD_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int NUM_REGS    = 16,
   parameter int SPI_MODE    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SCK,
   input  logic              _CS,
   input  logic              MOSI,
   output logic              MISO,
   output logic              MISO_OE,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [WORD_W-1:0] WR_DATA,
   output logic [ADDR_W-1:0] RD_ADDR,
   input  logic [WORD_W-1:0] RD_DATA,
   output logic              BUSY,
   output logic              ERR,
   output logic [1:0]        State
);
   import spi_pkg::*;

   localparam logic CPOL_L  = cpol(SPI_MODE);
   localparam logic CPHA_L  = cpha(SPI_MODE);
   localparam int   CNT_W   = $clog2(WORD_W);
   localparam int   CMD_BIT = cmd_bit(WORD_W);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic mosi_s;

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL_L)) u_sck_sync (
      .clk(CLK), .srst(RST), .din(SCK),
      .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
   );

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk(CLK), .srst(RST), .din(_CS),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );

   assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-2:0] in_shift_q, in_shift_d;
   logic [WORD_W-1:0] out_shift_q, out_shift_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0] wr_data_q, wr_data_d;
   logic              write_mode_q, write_mode_d;
   logic              wr_en_q, wr_en_d;
   logic              err_q, err_d;

   logic              sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
   logic              word_done;
   logic [WORD_W-1:0] word_in;

   function automatic logic [ADDR_W-1:0] wrap_addr(input int unsigned a);
      return ADDR_W'(a % NUM_REGS);
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   // Leading edge moves SCK away from its idle (CPOL) level.
   always_comb begin
      sck_edge    = sck_rise | sck_fall;
      lead_edge   = sck_edge & (sck_lvl ^ CPOL_L);
      trail_edge  = sck_edge & ~(sck_lvl ^ CPOL_L);
      sample_edge = CPHA_L ? trail_edge : lead_edge;
      shift_edge  = CPHA_L ? lead_edge : trail_edge;
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      in_shift_d   = in_shift_q;
      out_shift_d  = out_shift_q;
      addr_d       = addr_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      write_mode_d = write_mode_q;
      wr_en_d      = 1'b0;
      err_d        = 1'b0;
      word_done    = 1'b0;
      word_in      = {in_shift_q, mosi_s};

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d     = CMD;
               bit_cnt_d   = '0;
               out_shift_d = RD_DATA;
            end
         end
         CMD, DATA: begin
            if (sample_edge) begin
               in_shift_d = word_in[WORD_W-2:0];
               if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                  word_done = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = WAIT;
                  if (state_q == CMD) begin
                     write_mode_d = word_in[CMD_BIT];
                     addr_d       = wrap_addr(32'(word_in[ADDR_W-1:0]));
                  end else begin
                     if (write_mode_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = word_in;
                     end
                     addr_d = next_addr(addr_q);
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            // The first bit of each word is already on MISO from the (re)load, so
            // the shift edge before any sample in a word is skipped.
            end else if (shift_edge && bit_cnt_q != '0) begin
               out_shift_d = {out_shift_q[WORD_W-2:0], 1'b0};
            end
         end
         WAIT: begin
            out_shift_d = RD_DATA;
            state_d     = DATA;
         end
         default: state_d = IDLE;
      endcase

      // Deselect wins over everything except a word completing on the same cycle.
      if (state_q != IDLE && cs_rise) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         err_d     = (bit_cnt_q != '0) && !word_done;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mosi_sync_q  <= '0;
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         in_shift_q   <= '0;
         out_shift_q  <= '0;
         addr_q       <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         write_mode_q <= 1'b0;
         wr_en_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         mosi_sync_q  <= mosi_sync_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         in_shift_q   <= in_shift_d;
         out_shift_q  <= out_shift_d;
         addr_q       <= addr_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         write_mode_q <= write_mode_d;
         wr_en_q      <= wr_en_d;
         err_q        <= err_d;
      end
   end

   assign MISO    = out_shift_q[WORD_W-1];
   assign MISO_OE = (state_q != IDLE) && !cs_lvl;
   assign WR_EN   = wr_en_q;
   assign WR_ADDR = wr_addr_q;
   assign WR_DATA = wr_data_q;
   assign RD_ADDR = addr_q;
   assign BUSY    = (state_q != IDLE);
   assign ERR     = err_q;
   assign State   = state_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: mode-0 and mode-3 8-bit slaves plus four 12-bit
// slaves (one per SPI mode) sharing one SPI master with per-group chip selects.
module tb_spi_slave_fsm;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       sck_b = 1'b0;
   logic       mosi = 1'b0;
   logic [2:0] cs_n = 3'b111;

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // u0: mode 0, 8-bit
   logic       miso0, miso_oe0, wr_en0, busy0, err0;
   logic [3:0] wr_addr0, rd_addr0;
   logic [7:0] wr_data0, rd_data0;
   logic [1:0] state0;
   assign rd_data0 = {rd_addr0, 4'h0};

   spi_slave_fsm #(.WORD_W(8), .ADDR_W(4), .NUM_REGS(16), .SPI_MODE(0), .SYNC_STAGES(2)) u0 (
      .CLK(CLK), .RST(RST), .SCK(sck_b), ._CS(cs_n[0]), .MOSI(mosi),
      .MISO(miso0), .MISO_OE(miso_oe0), .WR_EN(wr_en0), .WR_ADDR(wr_addr0),
      .WR_DATA(wr_data0), .RD_ADDR(rd_addr0), .RD_DATA(rd_data0),
      .BUSY(busy0), .ERR(err0), .State(state0)
   );

   // u1: mode 3, 8-bit, register file modelled as address*0x10
   logic       miso1, miso_oe1, wr_en1, busy1, err1;
   logic [3:0] wr_addr1, rd_addr1;
   logic [7:0] wr_data1, rd_data1;
   logic [1:0] state1;
   assign rd_data1 = {rd_addr1, 4'h0};

   spi_slave_fsm #(.WORD_W(8), .ADDR_W(4), .NUM_REGS(16), .SPI_MODE(3), .SYNC_STAGES(2)) u1 (
      .CLK(CLK), .RST(RST), .SCK(~sck_b), ._CS(cs_n[1]), .MOSI(mosi),
      .MISO(miso1), .MISO_OE(miso_oe1), .WR_EN(wr_en1), .WR_ADDR(wr_addr1),
      .WR_DATA(wr_data1), .RD_ADDR(rd_addr1), .RD_DATA(rd_data1),
      .BUSY(busy1), .ERR(err1), .State(state1)
   );

   for (genvar gi = 0; gi < 4; gi++) begin : g_w12
      logic        miso, oe, we, busy, err;
      logic [3:0]  wa, ra, la;
      logic [11:0] wd, ld;
      logic [1:0]  st;
      int          cnt = 0;

      spi_slave_fsm #(.WORD_W(12), .ADDR_W(4), .NUM_REGS(16), .SPI_MODE(gi), .SYNC_STAGES(2)) u_dut (
         .CLK(CLK), .RST(RST), .SCK(sck_b ^ 1'(gi / 2)), ._CS(cs_n[2]), .MOSI(mosi),
         .MISO(miso), .MISO_OE(oe), .WR_EN(we), .WR_ADDR(wa),
         .WR_DATA(wd), .RD_ADDR(ra), .RD_DATA(12'h000),
         .BUSY(busy), .ERR(err), .State(st)
      );

      always @(posedge CLK) begin
         if (we) begin
            la  <= wa;
            ld  <= wd;
            cnt <= cnt + 1;
         end
      end
   end

   // Write/error logging for the 8-bit slaves
   int         wr_cnt0 = 0, err_cnt0 = 0, wr_cnt1 = 0;
   logic [3:0] wa0 [16];
   logic [7:0] wd0 [16];

   always @(posedge CLK) begin
      if (wr_en0) begin
         wa0[wr_cnt0[3:0]] <= wr_addr0;
         wd0[wr_cnt0[3:0]] <= wr_data0;
         wr_cnt0 <= wr_cnt0 + 1;
      end
      if (err0) err_cnt0 <= err_cnt0 + 1;
      if (wr_en1) wr_cnt1 <= wr_cnt1 + 1;
   end

   logic [7:0] rx1 = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One SPI bit: MOSI set mid-idle, leading edge, hold, capture u1 MISO, trailing edge.
   task automatic spi_bit(input logic b);
      #40 mosi = b;
      #40 sck_b = 1'b1;
      #80 rx1 = {rx1[6:0], miso1};
      sck_b = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) spi_bit(w[i]);
   endtask

   task automatic check_u0_idle(input string tag);
      check({tag, "_miso"},    32'(miso0), 0);
      check({tag, "_miso_oe"}, 32'(miso_oe0), 0);
      check({tag, "_wr_en"},   32'(wr_en0), 0);
      check({tag, "_wr_addr"}, 32'(wr_addr0), 0);
      check({tag, "_wr_data"}, 32'(wr_data0), 0);
      check({tag, "_rd_addr"}, 32'(rd_addr0), 0);
      check({tag, "_busy"},    32'(busy0), 0);
      check({tag, "_err"},     32'(err0), 0);
      check({tag, "_state"},   32'(state0), 0);
   endtask

   int wb, eb;

   initial begin
      // Reset state
      #50;
      check_u0_idle("reset");
      check("reset_u1_state", 32'(state1), 0);
      RST = 1'b0;
      #50;

      // 1: mode 0 write, cmd 0x83, data 0x5A 0xA5
      wb = wr_cnt0; eb = err_cnt0;
      cs_n[0] = 1'b0;
      #80;
      send_word(16'h83, 8); send_word(16'h5A, 8); send_word(16'hA5, 8);
      #80;
      check("t1_busy_in_frame", 32'(busy0), 1);
      cs_n[0] = 1'b1;
      #160;
      check("t1_wr_count", 32'(wr_cnt0 - wb), 2);
      check("t1_addr0", 32'(wa0[wb]), 3);
      check("t1_data0", 32'(wd0[wb]), 32'h5A);
      check("t1_addr1", 32'(wa0[wb+1]), 4);
      check("t1_data1", 32'(wd0[wb+1]), 32'hA5);
      check("t1_err", 32'(err_cnt0 - eb), 0);
      check("t1_busy_after", 32'(busy0), 0);

      // 2: address wrap, cmd 0x8F, data 0x11 0x22
      wb = wr_cnt0;
      cs_n[0] = 1'b0;
      #80;
      send_word(16'h8F, 8); send_word(16'h11, 8); send_word(16'h22, 8);
      #80 cs_n[0] = 1'b1;
      #160;
      check("t2_wr_count", 32'(wr_cnt0 - wb), 2);
      check("t2_addr0", 32'(wa0[wb]), 15);
      check("t2_data0", 32'(wd0[wb]), 32'h11);
      check("t2_addr1", 32'(wa0[wb+1]), 0);
      check("t2_data1", 32'(wd0[wb+1]), 32'h22);

      // 3: mode 3 read, cmd 0x02 -> 0x20, 0x30
      cs_n[1] = 1'b0;
      #80;
      send_word(16'h02, 8);
      rx1 = 8'h00;
      send_word(16'h00, 8);
      check("t3_miso_word0", 32'(rx1), 32'h20);
      send_word(16'h00, 8);
      check("t3_miso_word1", 32'(rx1), 32'h30);
      #80 cs_n[1] = 1'b1;
      #160;
      check("t3_no_wr_en", 32'(wr_cnt1), 0);
      check("t3_rd_addr", 32'(rd_addr1), 4);

      // 4: framing error after 3 data bits
      wb = wr_cnt0; eb = err_cnt0;
      cs_n[0] = 1'b0;
      #80;
      send_word(16'h81, 8); send_word(16'h5, 3);
      #80 cs_n[0] = 1'b1;
      #160;
      check("t4_err_count", 32'(err_cnt0 - eb), 1);
      check("t4_wr_count", 32'(wr_cnt0 - wb), 0);
      check("t4_state", 32'(state0), 0);

      // 5: reset after 5 data bits, then a normal transaction
      wb = wr_cnt0; eb = err_cnt0;
      cs_n[0] = 1'b0;
      #80;
      send_word(16'h81, 8); send_word(16'h1F, 5);
      #40;
      RST = 1'b1; cs_n[0] = 1'b1;
      #10;
      check_u0_idle("t5_abort");
      #30 RST = 1'b0;
      #50;
      check("t5_abort_no_wr", 32'(wr_cnt0 - wb), 0);
      check("t5_abort_no_err", 32'(err_cnt0 - eb), 0);
      cs_n[0] = 1'b0;
      #80;
      send_word(16'h84, 8); send_word(16'h3C, 8);
      #80 cs_n[0] = 1'b1;
      #160;
      check("t5_wr_count", 32'(wr_cnt0 - wb), 1);
      check("t5_addr", 32'(wa0[wb]), 4);
      check("t5_data", 32'(wd0[wb]), 32'h3C);

      // 6: all four modes at WORD_W = 12, cmd 0x805, data 0xABC
      cs_n[2] = 1'b0;
      #80;
      send_word(16'h805, 12); send_word(16'hABC, 12);
      #80 cs_n[2] = 1'b1;
      #160;
      check("t6_m0_count", 32'(g_w12[0].cnt), 1);
      check("t6_m0_addr",  32'(g_w12[0].la), 5);
      check("t6_m0_data",  32'(g_w12[0].ld), 32'hABC);
      check("t6_m0_state", 32'(g_w12[0].st), 0);
      check("t6_m1_count", 32'(g_w12[1].cnt), 1);
      check("t6_m1_addr",  32'(g_w12[1].la), 5);
      check("t6_m1_data",  32'(g_w12[1].ld), 32'hABC);
      check("t6_m1_state", 32'(g_w12[1].st), 0);
      check("t6_m2_count", 32'(g_w12[2].cnt), 1);
      check("t6_m2_addr",  32'(g_w12[2].la), 5);
      check("t6_m2_data",  32'(g_w12[2].ld), 32'hABC);
      check("t6_m2_state", 32'(g_w12[2].st), 0);
      check("t6_m3_count", 32'(g_w12[3].cnt), 1);
      check("t6_m3_addr",  32'(g_w12[3].la), 5);
      check("t6_m3_data",  32'(g_w12[3].ld), 32'hABC);
      check("t6_m3_state", 32'(g_w12[3].st), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
